// File: rtl/npu_sort_defs_pkg.sv
// Shared definitions for the PE sorter family: clog2, FSM encodings, element slice helpers.
package npu_sort_defs;

    localparam logic [0:0] SORT_IDLE = 1'b0;
    localparam logic [0:0] SORT_RUN  = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // LSB position of lane i in a flat vector of w-bit lanes
    function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned w);
        return i * w;
    endfunction

endpackage

// File: rtl/pe_sort_cmp_swap.sv
// One compare-exchange cell; lo lands in the lower lane, hi in the upper lane.
// Index pass-through ports exist only when PE_SORT_INDEX_EN is defined.
module pe_sort_cmp_swap #(
    parameter int unsigned DATA_W = 8
`ifdef PE_SORT_INDEX_EN
    , parameter int unsigned IDX_W = 6
`endif
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              desc,
`ifdef PE_SORT_INDEX_EN
    input  logic [IDX_W-1:0]  ia,
    input  logic [IDX_W-1:0]  ib,
    output logic [IDX_W-1:0]  idx_lo,
    output logic [IDX_W-1:0]  idx_hi,
`endif
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              swapped
);

    // Strict compare keeps equal elements in place, which makes the sort stable
    assign swapped = desc ? (a < b) : (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

`ifdef PE_SORT_INDEX_EN
    assign idx_lo  = swapped ? ib : ia;
    assign idx_hi  = swapped ? ia : ib;
`endif

endmodule

// File: rtl/pe_sort_seq.sv
// Sequential odd-even transposition sorter, one phase per clock, with early exit.
// Define PE_SORT_INDEX_EN to carry source lane indices and expose sorter_idx.
module pe_sort_seq
    import npu_sort_defs::*;
#(
    parameter  int unsigned N_ELEM = 32,
    parameter  int unsigned DATA_W = 8,
    localparam int unsigned CNT_W  = clog2(N_ELEM) + 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     sorter_clr,
    input  logic                     sorter_en,
    input  logic                     sort_desc,
    input  logic                     last_sort,
    input  logic [N_ELEM*DATA_W-1:0] sorter_in,
    output logic                     sorter_ready,
    output logic [N_ELEM*DATA_W-1:0] sorter_result,
    output logic                     sorter_valid,
    output logic                     last_sort_o
`ifdef PE_SORT_INDEX_EN
    ,
    output logic [N_ELEM*CNT_W-1:0]  sorter_idx
`endif
);

    localparam int unsigned VEC_W = N_ELEM * DATA_W;
    localparam int unsigned N_EVN = N_ELEM / 2;
    localparam int unsigned N_ODD = N_ELEM / 2 - 1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] phase_q;
    logic             desc_q, tag_q, settled_q;
    logic [VEC_W-1:0] work_q, even_c, odd_c, next_c;
    logic [N_EVN-1:0] even_sw_c;
    logic [N_ODD-1:0] odd_sw_c;
    logic             step_sw_c, accept_c, done_c;

`ifdef PE_SORT_INDEX_EN
    localparam int unsigned IVEC_W = N_ELEM * CNT_W;
    logic [IVEC_W-1:0] idx_q, idx_even_c, idx_odd_c, idx_next_c;

    function automatic logic [IVEC_W-1:0] lane_ids();
        logic [IVEC_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_ELEM); i++) r[i*CNT_W +: CNT_W] = CNT_W'(i);
        return r;
    endfunction
`endif

    // Even phase: pairs (0,1),(2,3),...
    for (genvar k = 0; k < int'(N_EVN); k++) begin : g_even
        localparam int unsigned L = elem_lsb(2*k, DATA_W);
        localparam int unsigned H = elem_lsb(2*k+1, DATA_W);
        pe_sort_cmp_swap #(
            .DATA_W (DATA_W)
`ifdef PE_SORT_INDEX_EN
            , .IDX_W (CNT_W)
`endif
        ) u_cell (
            .a       (work_q[L +: DATA_W]),
            .b       (work_q[H +: DATA_W]),
            .desc    (desc_q),
`ifdef PE_SORT_INDEX_EN
            .ia      (idx_q[2*k*CNT_W +: CNT_W]),
            .ib      (idx_q[(2*k+1)*CNT_W +: CNT_W]),
            .idx_lo  (idx_even_c[2*k*CNT_W +: CNT_W]),
            .idx_hi  (idx_even_c[(2*k+1)*CNT_W +: CNT_W]),
`endif
            .lo      (even_c[L +: DATA_W]),
            .hi      (even_c[H +: DATA_W]),
            .swapped (even_sw_c[k])
        );
    end

    // Odd phase: pairs (1,2),(3,4),...; the two end lanes pass straight through
    for (genvar k = 0; k < int'(N_ODD); k++) begin : g_odd
        localparam int unsigned L = elem_lsb(2*k+1, DATA_W);
        localparam int unsigned H = elem_lsb(2*k+2, DATA_W);
        pe_sort_cmp_swap #(
            .DATA_W (DATA_W)
`ifdef PE_SORT_INDEX_EN
            , .IDX_W (CNT_W)
`endif
        ) u_cell (
            .a       (work_q[L +: DATA_W]),
            .b       (work_q[H +: DATA_W]),
            .desc    (desc_q),
`ifdef PE_SORT_INDEX_EN
            .ia      (idx_q[(2*k+1)*CNT_W +: CNT_W]),
            .ib      (idx_q[(2*k+2)*CNT_W +: CNT_W]),
            .idx_lo  (idx_odd_c[(2*k+1)*CNT_W +: CNT_W]),
            .idx_hi  (idx_odd_c[(2*k+2)*CNT_W +: CNT_W]),
`endif
            .lo      (odd_c[L +: DATA_W]),
            .hi      (odd_c[H +: DATA_W]),
            .swapped (odd_sw_c[k])
        );
    end

    assign odd_c[DATA_W-1:0]         = work_q[DATA_W-1:0];
    assign odd_c[VEC_W-1 -: DATA_W]  = work_q[VEC_W-1 -: DATA_W];
`ifdef PE_SORT_INDEX_EN
    assign idx_odd_c[CNT_W-1:0]        = idx_q[CNT_W-1:0];
    assign idx_odd_c[IVEC_W-1 -: CNT_W] = idx_q[IVEC_W-1 -: CNT_W];
    assign idx_next_c = phase_q[0] ? idx_odd_c : idx_even_c;
`endif

    assign next_c       = phase_q[0] ? odd_c : even_c;
    assign step_sw_c    = phase_q[0] ? (|odd_sw_c) : (|even_sw_c);
    assign sorter_ready = (state_q == SORT_IDLE);
    assign accept_c     = sorter_en & sorter_ready & ~sorter_clr;
    // Done on the last phase, or when this and the previous phase were both swap-free
    assign done_c       = (state_q == SORT_RUN) &
                          ((phase_q == CNT_W'(N_ELEM - 1)) | (settled_q & ~step_sw_c));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= SORT_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sorter_clr) begin
            state_d = SORT_IDLE;
        end else begin
            case (state_q)
                SORT_IDLE: if (sorter_en) state_d = SORT_RUN;
                SORT_RUN:  if (done_c)    state_d = SORT_IDLE;
                default:                  state_d = SORT_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            work_q        <= '0;
            phase_q       <= '0;
            desc_q        <= 1'b0;
            tag_q         <= 1'b0;
            settled_q     <= 1'b0;
            sorter_result <= '0;
            sorter_valid  <= 1'b0;
            last_sort_o   <= 1'b0;
`ifdef PE_SORT_INDEX_EN
            idx_q         <= '0;
            sorter_idx    <= '0;
`endif
        end else begin
            sorter_valid <= 1'b0;
            if (sorter_clr) begin
                phase_q       <= '0;
                settled_q     <= 1'b0;
                sorter_result <= '0;
                last_sort_o   <= 1'b0;
`ifdef PE_SORT_INDEX_EN
                sorter_idx    <= '0;
`endif
            end else if (accept_c) begin
                work_q    <= sorter_in;
                desc_q    <= sort_desc;
                tag_q     <= last_sort;
                phase_q   <= '0;
                settled_q <= 1'b0;
`ifdef PE_SORT_INDEX_EN
                idx_q     <= lane_ids();
`endif
            end else if (state_q == SORT_RUN) begin
                work_q    <= next_c;
                phase_q   <= phase_q + CNT_W'(1);
                settled_q <= ~step_sw_c;
`ifdef PE_SORT_INDEX_EN
                idx_q     <= idx_next_c;
`endif
                if (done_c) begin
                    sorter_result <= next_c;
                    sorter_valid  <= 1'b1;
                    last_sort_o   <= tag_q;
`ifdef PE_SORT_INDEX_EN
                    sorter_idx    <= idx_next_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_sort_seq.sv
// Randomised bench for pe_sort_seq against a stable-sort reference model.
module tb_pe_sort_seq;

    localparam int unsigned N  = 32;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 6;
    localparam int unsigned DW = N * W;
    localparam int unsigned IW = N * CW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sorter_clr, sorter_en, sort_desc, last_sort;
    logic [DW-1:0] sorter_in;
    logic          sorter_ready, sorter_valid, last_sort_o;
    logic [DW-1:0] sorter_result;
`ifdef PE_SORT_INDEX_EN
    logic [IW-1:0] sorter_idx;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    pe_sort_seq #(.N_ELEM(N), .DATA_W(W)) dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .sorter_clr    (sorter_clr),
        .sorter_en     (sorter_en),
        .sort_desc     (sort_desc),
        .last_sort     (last_sort),
        .sorter_in     (sorter_in),
        .sorter_ready  (sorter_ready),
        .sorter_result (sorter_result),
        .sorter_valid  (sorter_valid),
`ifdef PE_SORT_INDEX_EN
        .sorter_idx    (sorter_idx),
`endif
        .last_sort_o   (last_sort_o)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_vec(input int unsigned maxv);
        logic [DW-1:0] r;
        for (int i = 0; i < int'(N); i++) r[i*W +: W] = W'($urandom_range(0, maxv));
        return r;
    endfunction

    // Reference: stable insertion sort for the result, phase-level replay for latency
    function automatic void model(input logic [DW-1:0] din, input logic desc,
                                  output logic [DW-1:0] res, output logic [IW-1:0] idx,
                                  output int lat);
        int v[N];
        int ix[N];
        int w[N];
        int p;
        int t;
        bit sw;
        bit prev;
        for (int i = 0; i < int'(N); i++) begin
            v[i]  = int'(din[i*W +: W]);
            ix[i] = i;
            w[i]  = v[i];
        end
        for (int i = 1; i < int'(N); i++) begin
            int kv;
            int ki;
            int j;
            kv = v[i];
            ki = ix[i];
            j  = i - 1;
            while (j >= 0 && (desc ? (kv > v[j]) : (kv < v[j]))) begin
                v[j+1]  = v[j];
                ix[j+1] = ix[j];
                j--;
            end
            v[j+1]  = kv;
            ix[j+1] = ki;
        end
        for (int i = 0; i < int'(N); i++) begin
            res[i*W +: W]   = W'(v[i]);
            idx[i*CW +: CW] = CW'(ix[i]);
        end
        prev = 1'b0;
        for (p = 0; p < int'(N); p++) begin
            sw = 1'b0;
            for (int j = p % 2; j + 1 < int'(N); j += 2) begin
                if (desc ? (w[j] < w[j+1]) : (w[j] > w[j+1])) begin
                    t = w[j]; w[j] = w[j+1]; w[j+1] = t;
                    sw = 1'b1;
                end
            end
            if (p == int'(N) - 1 || (p > 0 && !sw && !prev)) break;
            prev = sw;
        end
        lat = p + 1;
    endfunction

    // Called at a negedge with the block ready; returns at the negedge showing valid
    task automatic apply(input logic [DW-1:0] din, input logic desc, input logic tag, input bit poke);
        logic [DW-1:0] er;
        logic [IW-1:0] ei;
        int el;
        int cnt;
        model(din, desc, er, ei, el);
        chk("ready_before_accept", 256'(sorter_ready), 256'(1));
        sorter_in = din; sort_desc = desc; last_sort = tag; sorter_en = 1'b1;
        @(negedge clk);
        sorter_en = 1'b0;
        sorter_in = rnd_vec(255); sort_desc = ~desc; last_sort = ~tag;
        chk("ready_while_busy", 256'(sorter_ready), 256'(0));
        cnt = 0;
        while (!sorter_valid && cnt < int'(N) + 4) begin
            sorter_en = (poke && cnt == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            cnt++;
        end
        sorter_en = 1'b0;
        chk("latency", 256'(cnt), 256'(el));
        chk("result", 256'(sorter_result), 256'(er));
        chk("last_sort_o", 256'(last_sort_o), 256'(tag));
        chk("ready_with_valid", 256'(sorter_ready), 256'(1));
`ifdef PE_SORT_INDEX_EN
        chk("idx", 256'(sorter_idx), 256'(ei));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] din_asc, din_rev, d;
        int seen;
        rst_n = 1'b0; sorter_clr = 1'b0; sorter_en = 1'b0;
        sort_desc = 1'b0; last_sort = 1'b0; sorter_in = '0;
        for (int i = 0; i < int'(N); i++) begin
            din_asc[i*W +: W] = W'(i);
            din_rev[i*W +: W] = W'(N - 1 - i);
        end

        repeat (2) @(negedge clk);
        chk("rst_ready", 256'(sorter_ready), 256'(1));
        chk("rst_valid", 256'(sorter_valid), 256'(0));
        chk("rst_last", 256'(last_sort_o), 256'(0));
        chk("rst_result", 256'(sorter_result), 256'(0));
`ifdef PE_SORT_INDEX_EN
        chk("rst_idx", 256'(sorter_idx), 256'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Already-sorted ascending input
        apply(din_asc, 1'b0, 1'b0, 1'b0);
        chk("asc_identity", 256'(sorter_result), 256'(din_asc));
        @(negedge clk);
        chk("valid_one_pulse", 256'(sorter_valid), 256'(0));

        // Full reversal with a busy-time en poke, then a back-to-back beat
        apply(din_asc, 1'b1, 1'b1, 1'b1);
        chk("desc_reverse", 256'(sorter_result), 256'(din_rev));
        apply(rnd_vec(255), 1'b0, 1'b0, 1'b0);

        // Duplicates keep source order
        @(negedge clk);
        d = rnd_vec(255);
        d[0 +: W] = 8'h05; d[W +: W] = 8'h05; d[2*W +: W] = 8'h03; d[3*W +: W] = 8'h09;
        apply(d, 1'b0, 1'b1, 1'b0);

        // Synchronous clear mid-sort
        @(negedge clk);
        sorter_in = din_asc; sort_desc = 1'b1; last_sort = 1'b1; sorter_en = 1'b1;
        @(negedge clk);
        sorter_en = 1'b0;
        repeat (4) @(negedge clk);
        sorter_clr = 1'b1;
        @(negedge clk);
        sorter_clr = 1'b0;
        chk("clr_ready", 256'(sorter_ready), 256'(1));
        chk("clr_valid", 256'(sorter_valid), 256'(0));
        chk("clr_result", 256'(sorter_result), 256'(0));
        chk("clr_last", 256'(last_sort_o), 256'(0));
`ifdef PE_SORT_INDEX_EN
        chk("clr_idx", 256'(sorter_idx), 256'(0));
`endif
        seen = 0;
        repeat (N + 4) begin
            @(negedge clk);
            if (sorter_valid) seen++;
        end
        chk("clr_no_valid", 256'(seen), 256'(0));

        // Clear beats a simultaneous en
        sorter_in = din_asc; sorter_en = 1'b1; sorter_clr = 1'b1;
        @(negedge clk);
        sorter_en = 1'b0; sorter_clr = 1'b0;
        chk("clr_beats_en", 256'(sorter_ready), 256'(1));

        // Asynchronous reset mid-sort
        apply(rnd_vec(255), 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        sorter_in = din_asc; sort_desc = 1'b1; sorter_en = 1'b1;
        @(negedge clk);
        sorter_en = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 256'(sorter_ready), 256'(1));
        chk("arst_valid", 256'(sorter_valid), 256'(0));
        chk("arst_result", 256'(sorter_result), 256'(0));
        chk("arst_last", 256'(last_sort_o), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply(din_asc, 1'b1, 1'b1, 1'b0);

        // Random beats, mixing value ranges, modes and back-to-back issue
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       d = rnd_vec(3);
                1:       d = din_asc;
                2:       d = din_rev;
                default: d = rnd_vec(255);
            endcase
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                chk("rand_valid_low", 256'(sorter_valid), 256'(0));
            end
            apply(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
